// File: rtl/ce_rate_meter.sv
// rtl/ce_rate_meter.sv - clock-enable rate meter with tolerance compare and lock detection
// Counts CE pulses over a window of IN_CLK>>WIN_SHIFT master cycles and reports the scaled rate.

module ce_rate_meter #(
  parameter int WIN_SHIFT = 0,
  parameter int LOCK_WINS = 3
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN,
  input  logic        CE,
  input  logic [31:0] IN_CLK,
  input  logic [31:0] EXP_CLK,
  input  logic [15:0] TOL,
  output logic [31:0] MEAS_CLK,
  output logic        MEAS_VALID,
  output logic        IN_TOL,
  output logic        LOCKED
);

  typedef enum logic {S_IDLE, S_COUNT} meas_t;
  typedef enum logic [1:0] {L_UNLOCK, L_ACQUIRE, L_LOCK} lock_t;

  meas_t       r_state;
  lock_t       r_lock;
  logic [31:0] r_win_len;
  logic [31:0] r_win_cnt;
  logic [31:0] r_ce_cnt;
  logic [31:0] r_result;
  logic        r_pend;
  logic [3:0]  r_hit_cnt;

  logic [31:0] w_win_raw;
  logic [31:0] w_win_len;
  logic        w_last;
  logic [32:0] w_sum;
  logic [63:0] w_wide;
  logic [31:0] w_result;
  logic [32:0] w_diff;
  logic        w_hit;
  logic [3:0]  w_hit_inc;
  logic        w_lock_reach;

  // A zero-length window would never terminate, so clamp to one cycle.
  assign w_win_raw    = IN_CLK >> WIN_SHIFT;
  assign w_win_len    = (w_win_raw == 32'd0) ? 32'd1 : w_win_raw;
  assign w_last       = (r_win_cnt == r_win_len - 32'd1);
  assign w_sum        = {1'b0, r_ce_cnt} + {32'd0, CE};
  assign w_wide       = {31'd0, w_sum} << WIN_SHIFT;
  assign w_result     = (|w_wide[63:32]) ? 32'hFFFF_FFFF : w_wide[31:0];
  assign w_diff       = (r_result >= EXP_CLK) ? ({1'b0, r_result} - {1'b0, EXP_CLK})
                                              : ({1'b0, EXP_CLK} - {1'b0, r_result});
  assign w_hit        = (w_diff <= {17'd0, TOL});
  assign w_hit_inc    = r_hit_cnt + 4'd1;
  assign w_lock_reach = (w_hit_inc >= 4'(LOCK_WINS));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_lock     <= L_UNLOCK;
      r_win_len  <= 32'd1;
      r_win_cnt  <= 32'd0;
      r_ce_cnt   <= 32'd0;
      r_result   <= 32'd0;
      r_pend     <= 1'b0;
      r_hit_cnt  <= 4'd0;
      MEAS_CLK   <= 32'd0;
      MEAS_VALID <= 1'b0;
      IN_TOL     <= 1'b0;
      LOCKED     <= 1'b0;
    end else begin
      MEAS_VALID <= 1'b0;
      r_pend     <= 1'b0;
      if (!EN) begin
        r_state   <= S_IDLE;
        r_win_cnt <= 32'd0;
        r_ce_cnt  <= 32'd0;
        r_lock    <= L_UNLOCK;
        r_hit_cnt <= 4'd0;
        IN_TOL    <= 1'b0;
        LOCKED    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state   <= S_COUNT;
            r_win_len <= w_win_len;
            r_win_cnt <= 32'd0;
            r_ce_cnt  <= 32'd0;
          end
          default: begin
            // Window close folds in this cycle's CE so back-to-back windows drop nothing.
            if (w_last) begin
              r_result  <= w_result;
              r_pend    <= 1'b1;
              r_win_cnt <= 32'd0;
              r_ce_cnt  <= 32'd0;
              r_win_len <= w_win_len;
            end else begin
              r_win_cnt <= r_win_cnt + 32'd1;
              r_ce_cnt  <= w_sum[31:0];
            end
          end
        endcase

        if (r_pend) begin
          MEAS_CLK   <= r_result;
          MEAS_VALID <= 1'b1;
          IN_TOL     <= w_hit;
          case (r_lock)
            L_UNLOCK: begin
              if (w_hit) begin
                r_hit_cnt <= 4'd1;
                if (LOCK_WINS <= 1) begin
                  r_lock <= L_LOCK;
                  LOCKED <= 1'b1;
                end else begin
                  r_lock <= L_ACQUIRE;
                end
              end
            end
            L_ACQUIRE: begin
              if (w_hit) begin
                r_hit_cnt <= w_hit_inc;
                if (w_lock_reach) begin
                  r_lock <= L_LOCK;
                  LOCKED <= 1'b1;
                end
              end else begin
                r_lock    <= L_UNLOCK;
                r_hit_cnt <= 4'd0;
              end
            end
            L_LOCK: begin
              if (!w_hit) begin
                r_lock    <= L_UNLOCK;
                r_hit_cnt <= 4'd0;
                LOCKED    <= 1'b0;
              end
            end
            default: begin
              r_lock    <= L_UNLOCK;
              r_hit_cnt <= 4'd0;
              LOCKED    <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
